// File: rtl/ydemux_stream_if.sv
// Bundle of signals between a producer, the demux and its per-destination consumers.
// The slave modport is the demux itself; the master modport is the producer/consumer side.
interface ydemux_stream_if #(
  parameter int WIDTH = 2,
  parameter int NOUT  = 2,
  parameter int SELW  = 1
);
  logic [WIDTH-1:0]      in_data;
  logic [SELW-1:0]       in_sel;
  logic                  in_valid;
  logic                  in_ready;
  logic [NOUT*WIDTH-1:0] out_data;
  logic [NOUT-1:0]       out_valid;
  logic [NOUT-1:0]       out_ready;
  logic                  err;
  logic [7:0]            drop_cnt;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, err, drop_cnt
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, err, drop_cnt
  );
endinterface

// File: rtl/ydemux_stream.sv
// Registered 1-to-N stream demultiplexer.
// Each output port owns a one-entry holding buffer with its own valid/ready handshake.
// A port that is draining can be refilled in the same cycle, so a stream aimed at a
// ready consumer moves one word per cycle. Words whose select lands beyond the last
// port are accepted and thrown away, flagged by a one-cycle err pulse and counted.
module ydemux_stream #(
  parameter int WIDTH = 2,
  parameter int NOUT  = 2,
  parameter int SELW  = 1
) (
  input logic            clk,
  input logic            rst,
  ydemux_stream_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } port_state_t;

  port_state_t      state_q [NOUT];
  port_state_t      state_d [NOUT];
  logic [WIDTH-1:0] data_q  [NOUT];
  logic [NOUT-1:0]  fill;
  logic [NOUT-1:0]  drain;
  logic             in_ready_c;
  logic             sel_in_range;
  logic             accept;
  logic             drop;
  logic             err_q;
  logic [7:0]       drop_q;

  // Readiness follows the addressed port only: free if empty or being drained; a bad select is always taken
  always_comb begin
    in_ready_c   = 1'b1;
    sel_in_range = 1'b0;
    for (int i = 0; i < NOUT; i++) begin
      if (bus.in_sel == SELW'(i)) begin
        sel_in_range = 1'b1;
        in_ready_c   = (state_q[i] == EMPTY) || bus.out_ready[i];
      end
    end
  end

  assign accept = bus.in_valid & in_ready_c;
  assign drop   = accept & ~sel_in_range;

  // Per-port fill and drain strobes for this cycle
  always_comb begin
    fill  = '0;
    drain = '0;
    for (int i = 0; i < NOUT; i++) begin
      fill[i]  = accept && (bus.in_sel == SELW'(i));
      drain[i] = (state_q[i] == FULL) && bus.out_ready[i];
    end
  end

  // Next-state logic: a refill while draining keeps the buffer full
  always_comb begin
    for (int i = 0; i < NOUT; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        EMPTY:   if (fill[i]) state_d[i] = FULL;
        FULL:    if (drain[i] && !fill[i]) state_d[i] = EMPTY;
        default: state_d[i] = EMPTY;
      endcase
    end
  end

  // Buffer state registers
  always_ff @(posedge clk) begin
    for (int i = 0; i < NOUT; i++) begin
      if (rst) state_q[i] <= EMPTY;
      else     state_q[i] <= state_d[i];
    end
  end

  // Buffer data only changes on a fill, so a stalled word stays put for its consumer
  always_ff @(posedge clk) begin
    for (int i = 0; i < NOUT; i++) begin
      if (rst)          data_q[i] <= '0;
      else if (fill[i]) data_q[i] <= bus.in_data;
    end
  end

  // Error pulse and saturating drop counter for discarded words
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= 1'b0;
      drop_q <= 8'd0;
    end else begin
      err_q <= drop;
      if (drop && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

  // Flatten the buffers onto the output bus
  always_comb begin
    bus.out_valid = '0;
    bus.out_data  = '0;
    for (int i = 0; i < NOUT; i++) begin
      bus.out_valid[i]                = (state_q[i] == FULL);
      bus.out_data[i*WIDTH +: WIDTH]  = data_q[i];
    end
  end

  assign bus.in_ready = in_ready_c;
  assign bus.err      = err_q;
  assign bus.drop_cnt = drop_q;

endmodule

// File: tb/tb_ydemux_stream.sv
// Bench for ydemux_stream with three ports behind a two-bit select, so select 3 is out of range.
// The driver pushes each accepted word onto a per-port expected queue; a monitor on the
// falling edge checks port contents against those queues and the handshake flags
// against a simple behavioural model of buffer occupancy, err and the drop count.
module tb_ydemux_stream;
  localparam int WIDTH = 2;
  localparam int NOUT  = 3;
  localparam int SELW  = 2;

  logic clk = 1'b0;
  logic rst;

  ydemux_stream_if #(.WIDTH(WIDTH), .NOUT(NOUT), .SELW(SELW)) bus ();

  ydemux_stream #(.WIDTH(WIDTH), .NOUT(NOUT), .SELW(SELW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] exp_q [NOUT][$];

  bit              model_ok   = 1'b0;
  bit              rand_ready = 1'b0;
  logic [NOUT-1:0] m_valid;
  logic            m_err;
  int              m_drop;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Offer one word until it is accepted; called and returns one time unit after a rising edge
  task automatic apply_stimulus(input logic [WIDTH-1:0] d, input logic [SELW-1:0] s, output int waited);
    bit done;
    done   = 1'b0;
    waited = 0;
    bus.in_data  = d;
    bus.in_sel   = s;
    bus.in_valid = 1'b1;
    while (!done && waited < 64) begin
      #2;
      if (bus.in_ready === 1'b1) begin
        if (int'(s) < NOUT) exp_q[int'(s)].push_back(d);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      if (!done) waited++;
    end
    bus.in_valid = 1'b0;
    if (!done) check_output("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < NOUT; i++) exp_q[i].delete();
  endtask

  // Randomised consumer readiness while enabled
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_ready) bus.out_ready = NOUT'($urandom_range(0, 7));
    end
  end

  // Monitor: compare outputs with the model and queues, then advance the model from the sampled inputs
  initial begin
    int   sel_i;
    logic m_ready;
    forever begin
      @(negedge clk);
      sel_i   = int'(bus.in_sel);
      m_ready = (sel_i >= NOUT) ? 1'b1 : (!m_valid[sel_i] || bus.out_ready[sel_i]);
      if (model_ok) begin
        check_output("out_valid", 32'(bus.out_valid), 32'(m_valid));
        check_output("err", 32'(bus.err), 32'(m_err));
        check_output("drop_cnt", 32'(bus.drop_cnt), m_drop);
        check_output("in_ready", 32'(bus.in_ready), 32'(m_ready));
        for (int i = 0; i < NOUT; i++) begin
          if (bus.out_valid[i] === 1'b1) begin
            check_output($sformatf("port%0d_word_expected", i), 32'(exp_q[i].size() > 0), 32'd1);
            if (exp_q[i].size() > 0) begin
              check_output($sformatf("port%0d_data", i), 32'(bus.out_data[i*WIDTH +: WIDTH]), 32'(exp_q[i][0]));
              if (bus.out_ready[i] === 1'b1 && rst === 1'b0) void'(exp_q[i].pop_front());
            end
          end
        end
      end
      if (rst === 1'b1) begin
        m_valid  = '0;
        m_err    = 1'b0;
        m_drop   = 0;
        model_ok = 1'b1;
      end else begin
        for (int i = 0; i < NOUT; i++) if (m_valid[i] && bus.out_ready[i]) m_valid[i] = 1'b0;
        m_err = 1'b0;
        if (bus.in_valid && m_ready) begin
          if (sel_i < NOUT) m_valid[sel_i] = 1'b1;
          else begin
            m_err = 1'b1;
            if (m_drop < 255) m_drop++;
          end
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  // Directed scenarios followed by a randomised stream
  initial begin
    int w;
    rst           = 1'b1;
    bus.in_data   = '0;
    bus.in_sel    = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = '0;
    do_reset();
    check_output("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("reset_out_data", 32'(bus.out_data), 32'd0);
    check_output("reset_drop_cnt", 32'(bus.drop_cnt), 32'd0);
    check_output("reset_err", 32'(bus.err), 32'd0);

    $display("[TB] basic steer");
    apply_stimulus(2'b10, 2'd0, w);
    check_output("steer_wait", w, 0);
    check_output("steer_valid", 32'(bus.out_valid), 32'b001);
    check_output("steer_data", 32'(bus.out_data[1:0]), 32'b10);
    bus.in_sel = 2'd0;
    #1;
    check_output("in_ready_full_port", 32'(bus.in_ready), 32'd0);
    bus.in_sel = 2'd1;
    #1;
    check_output("in_ready_empty_port", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.out_ready = 3'b001;
    idle(1);
    bus.out_ready = 3'b000;

    $display("[TB] backpressure hold");
    apply_stimulus(2'b11, 2'd1, w);
    bus.in_data  = 2'b01;
    bus.in_sel   = 2'd1;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #2;
      check_output("backpressure_in_ready", 32'(bus.in_ready), 32'd0);
      check_output("backpressure_hold_data", 32'(bus.out_data[3:2]), 32'b11);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 3'b010;
    apply_stimulus(2'b01, 2'd1, w);
    bus.out_ready = 3'b000;
    check_output("release_wait", w, 0);
    check_output("release_valid", 32'(bus.out_valid[1]), 32'd1);
    check_output("release_data", 32'(bus.out_data[3:2]), 32'b01);
    bus.out_ready = 3'b010;
    idle(1);

    $display("[TB] streaming");
    bus.out_ready = 3'b011;
    for (int d = 0; d < 4; d++) begin
      for (int s = 0; s < 2; s++) begin
        apply_stimulus(WIDTH'(d), SELW'(s), w);
        check_output("stream_wait", w, 0);
      end
    end
    idle(2);
    bus.out_ready = 3'b000;

    $display("[TB] simultaneous drain and fill");
    apply_stimulus(2'b00, 2'd0, w);
    apply_stimulus(2'b01, 2'd1, w);
    bus.out_ready = 3'b011;
    apply_stimulus(2'b11, 2'd0, w);
    bus.out_ready = 3'b000;
    check_output("simul_wait", w, 0);
    check_output("simul_valid", 32'(bus.out_valid[1:0]), 32'b01);
    check_output("simul_data", 32'(bus.out_data[1:0]), 32'b11);

    $display("[TB] out-of-range select");
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(2'b01, 2'd3, w);
      check_output("oor_err_pulse", 32'(bus.err), 32'd1);
      idle(1);
      check_output("oor_err_clear", 32'(bus.err), 32'd0);
    end
    check_output("oor_drop_cnt_3", 32'(bus.drop_cnt), 32'd3);
    check_output("oor_valid_unchanged", 32'(bus.out_valid), 32'b001);
    for (int k = 0; k < 300; k++) apply_stimulus(WIDTH'($urandom), 2'd3, w);
    check_output("oor_drop_cnt_sat", 32'(bus.drop_cnt), 32'd255);
    idle(1);

    $display("[TB] randomised stream");
    do_reset();
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      apply_stimulus(WIDTH'($urandom), SELW'($urandom_range(0, 3)), w);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    rand_ready    = 1'b0;
    bus.out_ready = 3'b111;
    idle(3);
    bus.out_ready = 3'b000;

    $display("[TB] reset mid-operation");
    do_reset();
    apply_stimulus(2'b10, 2'd0, w);
    apply_stimulus(2'b01, 2'd1, w);
    for (int k = 0; k < 5; k++) apply_stimulus(2'b00, 2'd3, w);
    check_output("pre_reset_drop_cnt", 32'(bus.drop_cnt), 32'd5);
    check_output("pre_reset_valid", 32'(bus.out_valid), 32'b011);
    rst          = 1'b1;
    bus.in_data  = 2'b10;
    bus.in_sel   = 2'd2;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < NOUT; i++) exp_q[i].delete();
    check_output("mid_reset_valid", 32'(bus.out_valid), 32'd0);
    check_output("mid_reset_data", 32'(bus.out_data), 32'd0);
    check_output("mid_reset_drop_cnt", 32'(bus.drop_cnt), 32'd0);
    check_output("mid_reset_err", 32'(bus.err), 32'd0);
    idle(1);
    check_output("mid_reset_not_captured", 32'(bus.out_valid), 32'd0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
